// File: rtl/fx_div_32x11.sv
// Sequential signed fixed-point divider: q = trunc((p << FRAC) / y), saturated to PW bits.
// Define FX_DIV_ROUND_EN to round the quotient half away from zero instead of truncating.
module fx_div_32x11 #(
  parameter int PW   = 32,
  parameter int YW   = 11,
  parameter int FRAC = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] p,
  input  logic [YW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] q,
  output logic [YW-1:0] rem,
  output logic          div_zero,
  output logic          ovf
);

  localparam int DW = PW + FRAC;  // internal dividend / quotient magnitude width
  localparam int MW = YW + 1;     // divisor magnitude width (holds 2^(YW-1))
  localparam int RW = YW + 2;     // signed partial remainder width
  localparam int CW = 6;

  localparam logic [PW-1:0] Q_POS   = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] Q_NEG   = {1'b1, {(PW-1){1'b0}}};
  localparam logic [DW-1:0] POS_MAX = {{(DW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MAX = POS_MAX + 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          sign_n, sign_d;
  logic [DW-1:0] dvd;
  logic [MW-1:0] dvs;
  logic [RW-1:0] prem;

  logic [PW-1:0] q_r;
  logic [YW-1:0] rem_r;
  logic          dz_r, ovf_r;

  logic          accept, y_zero;
  logic [DW-1:0] p_ext, p_mag;
  logic [MW-1:0] y_ext, y_mag;
  logic [RW-1:0] dvs_x, prem_sh, prem_nx;

  logic [YW-1:0] rem_fix, rem_fix_s;
  logic [DW-1:0] qmag;
  logic          neg, sat;
  logic [PW-1:0] q_fix;

  assign accept = in_valid & in_ready;
  assign y_zero = (y == '0);

  // Operand magnitudes; the negations are exact because both widths carry one spare bit.
  always_comb begin
    p_ext = {p, {FRAC{1'b0}}};
    p_mag = p[PW-1] ? (~p_ext + 1'b1) : p_ext;
    y_ext = {y[YW-1], y};
    y_mag = y[YW-1] ? (~y_ext + 1'b1) : y_ext;
  end

  // Non-restoring step: shift in the next dividend bit, add or subtract by remainder sign.
  always_comb begin
    dvs_x   = {1'b0, dvs};
    prem_sh = {prem[RW-2:0], dvd[DW-1]};
    prem_nx = prem[RW-1] ? (prem_sh + dvs_x) : (prem_sh - dvs_x);
  end

  // Final correction, optional rounding, sign application and saturation.
  always_comb begin
    rem_fix = prem[YW-1:0] + (prem[RW-1] ? dvs[YW-1:0] : '0);
    qmag    = dvd;
`ifdef FX_DIV_ROUND_EN
    if ({rem_fix, 1'b0} >= dvs) qmag = dvd + 1'b1;
`endif
    neg   = sign_n ^ sign_d;
    sat   = 1'b0;
    q_fix = '0;
    if (!neg) begin
      sat   = (qmag > POS_MAX);
      q_fix = sat ? Q_POS : qmag[PW-1:0];
    end else begin
      sat   = (qmag > NEG_MAX);
      q_fix = sat ? Q_NEG : (~qmag[PW-1:0] + 1'b1);
    end
    rem_fix_s = sign_n ? (~rem_fix + 1'b1) : rem_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = y_zero ? DONE : DIV;
      DIV:  if (cnt == CNT_LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sign_n <= 1'b0;
      sign_d <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      q_r    <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_n <= p[PW-1];
            sign_d <= y[YW-1];
            dvd    <= p_mag;
            dvs    <= y_mag;
            prem   <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= y_zero;
            if (y_zero) begin
              q_r   <= p[PW-1] ? Q_NEG : Q_POS;
              rem_r <= '0;
            end
          end
        end
        DIV: begin
          prem <= prem_nx;
          dvd  <= {dvd[DW-2:0], ~prem_nx[RW-1]};
          cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        FIX: begin
          q_r   <= q_fix;
          rem_r <= rem_fix_s;
          ovf_r <= sat;
        end
        default: ;
      endcase
    end
  end

  assign q        = q_r;
  assign rem      = rem_r;
  assign div_zero = dz_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_fx_div_32x11.sv
// Randomised self-checking bench for fx_div_32x11 against an integer-arithmetic reference model.
module tb_fx_div_32x11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p;
  logic [10:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [10:0] rem;
  logic        div_zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fx_div_32x11 #(.PW(32), .YW(11), .FRAC(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .p(p), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .rem(rem), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed integer division of p*2^10 by y.
  function automatic void model(input logic [31:0] pp, input logic [10:0] yy,
                                output logic [31:0] eq, output logic [10:0] er,
                                output logic edz, output logic eov);
    longint num, den, an, ad, qm, rm;
    bit neg;
    eov = 1'b0;
    if (yy == 11'd0) begin
      eq  = pp[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      er  = '0;
      edz = 1'b1;
      return;
    end
    edz = 1'b0;
    num = longint'($signed(pp)) * 1024;
    den = longint'($signed(yy));
    an  = (num < 0) ? -num : num;
    ad  = (den < 0) ? -den : den;
    qm  = an / ad;
    rm  = an % ad;
`ifdef FX_DIV_ROUND_EN
    if (2 * rm >= ad) qm = qm + 1;
`endif
    neg = (num < 0) != (den < 0);
    if (!neg && qm > 64'h7FFF_FFFF) begin
      eq = 32'h7FFF_FFFF; eov = 1'b1;
    end else if (neg && qm > 64'h8000_0000) begin
      eq = 32'h8000_0000; eov = 1'b1;
    end else begin
      eq = neg ? 32'(-qm) : 32'(qm);
    end
    er = (num < 0) ? 11'(-rm) : 11'(rm);
  endfunction

  // Issue one operation and wait (bounded) for out_valid; lat counts edges including the accept edge.
  task automatic run_op(input logic [31:0] pp, input logic [10:0] yy, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got %b want 1", in_ready);
    end
    p = pp; y = yy; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin step(); lat++; end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; p = '0; y = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, q, rem, div_zero, ovf} !== {1'b1, 1'b0, 32'h0, 11'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b q=%h rem=%h dz=%b ovf=%b want rdy=1 vld=0 q=0 rem=0 dz=0 ovf=0",
               in_ready, out_valid, q, rem, div_zero, ovf);
    end
  endtask

  typedef struct {
    logic [31:0] p;
    logic [10:0] y;
    logic [31:0] q;
    logic [10:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[11];
    int lat;
`ifdef FX_DIV_ROUND_EN
    logic [31:0] q23 = 32'd683;
`else
    logic [31:0] q23 = 32'd682;
`endif
    v[0]  = '{32'd500,        11'd512,  32'd1000,       11'd0,     1'b0, 1'b0, 44};
    v[1]  = '{32'hFFFF_FE0C,  11'd512,  32'hFFFF_FC18,  11'd0,     1'b0, 1'b0, 44};
    v[2]  = '{32'hFFFF_FFF9,  11'd3,    32'hFFFF_F6AB,  11'h7FF,   1'b0, 1'b0, 44};
    v[3]  = '{32'd2,          11'd3,    q23,            11'd2,     1'b0, 1'b0, 44};
    v[4]  = '{32'd7,          11'd3,    32'd2389,       11'd1,     1'b0, 1'b0, 44};
    v[5]  = '{32'h7FFF_FFFF,  11'd1,    32'h7FFF_FFFF,  11'd0,     1'b0, 1'b1, 44};
    v[6]  = '{32'h8000_0000,  11'h400,  32'h7FFF_FFFF,  11'd0,     1'b0, 1'b1, 44};
    v[7]  = '{32'h0020_0000,  11'h7FF,  32'h8000_0000,  11'd0,     1'b0, 1'b0, 44};
    v[8]  = '{32'd0,          11'd77,   32'd0,          11'd0,     1'b0, 1'b0, 44};
    v[9]  = '{32'd5,          11'd0,    32'h7FFF_FFFF,  11'd0,     1'b1, 1'b0, 1};
    v[10] = '{32'hFFFF_FFFB,  11'd0,    32'h8000_0000,  11'd0,     1'b1, 1'b0, 1};
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].p, v[i].y, lat);
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({q, rem, div_zero, ovf} !== {v[i].q, v[i].r, v[i].dz, v[i].ov}) begin
        errors++;
        $display("FAIL dir_result[%0d] p=%h y=%h got q=%h rem=%h dz=%b ovf=%b want q=%h rem=%h dz=%b ovf=%b",
                 i, v[i].p, v[i].y, q, rem, div_zero, ovf, v[i].q, v[i].r, v[i].dz, v[i].ov);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [31:0] rp, eq;
    logic [10:0] ry, er;
    logic edz, eov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      rp = (i % 2 == 0) ? $urandom : (32'($urandom_range(0, 20000)) - 32'd10000);
      ry = 11'($urandom_range(0, 2047));
      model(rp, ry, eq, er, edz, eov);
      run_op(rp, ry, lat);
      checks++;
      if (lat !== (edz ? 1 : 44)) begin
        errors++;
        $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, edz ? 1 : 44);
      end
      checks++;
      if ({q, rem, div_zero, ovf} !== {eq, er, edz, eov}) begin
        errors++;
        $display("FAIL rnd_result[%0d] p=%h y=%h got q=%h rem=%h dz=%b ovf=%b want q=%h rem=%h dz=%b ovf=%b",
                 i, rp, ry, q, rem, div_zero, ovf, eq, er, edz, eov);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq;
    logic [10:0] er;
    logic edz, eov;
    int lat;
    logic [31:0] bp[3] = '{32'd1234, 32'hFFFF_0000, 32'd99};
    logic [10:0] by[3] = '{11'd0, 11'd37, 11'h7F0};
    for (int i = 0; i < 3; i++) begin
      model(bp[i], by[i], eq, er, edz, eov);
      run_op(bp[i], by[i], lat);
      checks++;
      if ({q, rem, div_zero, ovf} !== {eq, er, edz, eov}) begin
        errors++;
        $display("FAIL b2b_result[%0d] got q=%h rem=%h dz=%b ovf=%b want q=%h rem=%h dz=%b ovf=%b",
                 i, q, rem, div_zero, ovf, eq, er, edz, eov);
      end
      release_result();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_handshake[%0d] got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [31:0] eq;
    logic [10:0] er;
    logic edz, eov;
    int n;
    model(32'd7, 11'd3, eq, er, edz, eov);
    p = 32'd7; y = 11'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", in_ready);
    end
    p = 32'd123; y = 11'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    checks++;
    if ({out_valid, q, rem, div_zero, ovf} !== {1'b1, eq, er, edz, eov}) begin
      errors++;
      $display("FAIL busy_ignore got vld=%b q=%h rem=%h want vld=1 q=%h rem=%h", out_valid, q, rem, eq, er);
    end
    release_result();
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) n++;
      step();
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL busy_queued got %0d valid cycles want 0", n);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rp, eq;
    logic [10:0] ry, er;
    logic edz, eov;
    int lat;
    rp = 32'hFFF1_2345;
    ry = 11'd291;
    model(rp, ry, eq, er, edz, eov);
    run_op(rp, ry, lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, q, rem, div_zero, ovf} !== {1'b1, 1'b0, eq, er, edz, eov}) begin
        errors++;
        $display("FAIL hold[%0d] got vld=%b rdy=%b q=%h rem=%h want vld=1 rdy=0 q=%h rem=%h",
                 i, out_valid, in_ready, q, rem, eq, er);
      end
      step();
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [31:0] eq;
    logic [10:0] er;
    logic edz, eov;
    int lat;
    p = 32'd12345; y = 11'h7B3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, q, rem, div_zero, ovf} !== {1'b1, 1'b0, 32'h0, 11'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b q=%h want rdy=1 vld=0 q=0", in_ready, out_valid, q);
    end
    model(32'hFFFF_8000, 11'd100, eq, er, edz, eov);
    run_op(32'hFFFF_8000, 11'd100, lat);
    checks++;
    if ({lat == 44, q, rem, div_zero, ovf} !== {1'b1, eq, er, edz, eov}) begin
      errors++;
      $display("FAIL mid_reset_next got lat=%0d q=%h rem=%h want lat=44 q=%h rem=%h", lat, q, rem, eq, er);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_in_valid();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_div_32x11.md
Name: fx_div_32x11

Overview:
- Sequential signed fixed-point divider that inverts the team's 32x11 radix-4 Booth multiplier, which computes p = (x*y)>>10 truncated.
- Given p (32b) and coefficient y (11b), returns q = trunc((p<<FRAC)/y), i.e. recovers the x operand.
- Sits beside the filter datapath for coefficient normalisation and gain inversion.
- Radix-2 non-restoring iteration on magnitudes, with valid/ready handshakes on input and output.

Parameters:
- PW, 32, dividend/quotient width (p, q)
- YW, 11, divisor width (y, rem)
- FRAC, 10, left shift applied to p before division; internal dividend width is PW+FRAC = 42

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- p  in  32  signed dividend (two's complement)
- y  in  11  signed divisor (two's complement)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  32  signed quotient, saturated
- rem  out  11  signed remainder; sign follows the dividend
- div_zero  out  1  y was 0
- ovf  out  1  quotient saturated

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, q=0, rem=0, div_zero=0, ovf=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation, discards the in-flight result and returns to IDLE on the next edge.
- Accept: operands are captured on an edge where in_valid & in_ready. in_ready=1 only in IDLE. in_valid in other states is ignored and nothing is queued.
- On accept:
  - Store sign_n = p[31], sign_d = y[10].
  - Store dividend magnitude |{p,10'b0}| in a 42b register.
  - Store divisor magnitude |y| in 12b (y=-1024 gives 1024).
- States:
  - IDLE -> DIV on accept with y!=0.
  - IDLE -> DONE on accept with y==0.
  - DIV: one quotient bit per cycle, MSB first. Uses a 13b signed partial remainder and a 6b counter running 0..41; leaves for FIX after 42 iterations.
  - FIX: final non-restoring remainder correction (add back |y| if the partial remainder is negative). Then:
    - Apply sign: q negated if sign_n^sign_d; rem negated if sign_n.
    - Saturate: a positive result >2^31-1 gives 0x7FFFFFFF; a negative result with magnitude >2^31 gives 0x80000000. Either case sets ovf=1.
    - Go to DONE.
  - DONE: out_valid=1 and q/rem/div_zero/ovf held stable. On out_valid & out_ready go to IDLE; in_ready rises the following cycle.
- Latency: out_valid asserts 44 edges after the accepting edge (42 DIV, 1 FIX, 1 into DONE). For y==0 it asserts 1 edge after accept.
- Divide by zero: q = p[31] ? 0x80000000 : 0x7FFFFFFF, rem=0, div_zero=1, ovf=0.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable. There is no throughput overlap: at most one operation in flight.
- Outputs change only on entry to DONE. div_zero and ovf are cleared on the next accept.
- p=0 with any nonzero y gives q=0, rem=0.

Optional Feature:
- Macro: FX_DIV_ROUND_EN.
- Defined: FIX rounds half away from zero. If 2*|rem_mag| >= |y|, the quotient magnitude is incremented before sign application and saturation. A saturation caused by the increment sets ovf.
- rem still reports the truncating remainder. Latency is unchanged.
- Undefined: truncation toward zero only, and no rounding logic is synthesized.

Test Plan:
- Exact inverse: p=500 (0x000001F4), y=512 -> q=1000 (0x000003E8), rem=0, ovf=0, div_zero=0. out_valid exactly 44 edges after accept.
- Negative dividend: p=0xFFFFFE0C (-500), y=512 -> q=0xFFFFFC18 (-1000), rem=0.
  - Also: p=-7, y=3 -> q=-2389 (0xFFFFF6AB), rem=-1 (0x7FF).
- Inexact/rounding: p=2, y=3 -> q=682 (0x2AA), rem=2; with FX_DIV_ROUND_EN, q=683.
  - Also: p=7, y=3 -> q=2389 (0x955), rem=1 in both builds.
- Saturation:
  - p=0x7FFFFFFF, y=1 -> q=0x7FFFFFFF, ovf=1.
  - p=0x80000000, y=-1024 -> q=0x7FFFFFFF, ovf=1.
  - p=0x80000000, y=1024 is not representable; use y=-1: p=1<<21, y=-1 -> q=0x80000000, ovf=0 (magnitude exactly 2^31).
- Divide by zero: p=5, y=0 -> out_valid 1 edge after accept, q=0x7FFFFFFF, div_zero=1.
  - Also: p=-5, y=0 -> q=0x80000000, div_zero=1.
- Handshake/reset:
  - in_valid pulsed during DIV is ignored (in_ready=0).
  - out_ready held low for 10 cycles keeps out_valid and q stable.
  - rst asserted at iteration 20 gives in_ready=1, out_valid=0 next cycle; a new accept then completes correctly.
